// File: rtl/msi_pkg.sv
`default_nettype none
// ============================================================================
// Module : msi_pkg
// Desc   : Shared types, encodings and address helpers for the MSI L1 cache.
// Rev    : 1.0 - initial release
// ============================================================================
package msi_pkg;

   localparam int MSI_ADDR_W = 32;
   localparam int MSI_DATA_W = 32;
   localparam int MSI_IDX_W  = 4;
   localparam int MSI_TAG_W  = MSI_ADDR_W - MSI_IDX_W - 2;

   typedef enum logic [1:0] {
      LS_I = 2'd0,
      LS_S = 2'd1,
      LS_M = 2'd2
   } line_state_t;

   typedef enum logic [1:0] {
      CMD_NONE   = 2'd0,
      CMD_BUSRD  = 2'd1,
      CMD_BUSRDX = 2'd2,
      CMD_WB     = 2'd3
   } bus_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WB   = 2'd1,
      ST_FILL = 2'd2,
      ST_RESP = 2'd3
   } fsm_state_t;

   function automatic logic [MSI_IDX_W-1:0] msi_index(input logic [MSI_ADDR_W-1:0] addr);
      return addr[MSI_IDX_W+1:2];
   endfunction

   function automatic logic [MSI_TAG_W-1:0] msi_tag(input logic [MSI_ADDR_W-1:0] addr);
      return addr[MSI_ADDR_W-1:MSI_IDX_W+2];
   endfunction

endpackage
`default_nettype wire

// File: rtl/msi_cache_array.sv
`default_nettype none
// ============================================================================
// Module : msi_cache_array
// Desc   : Direct-mapped tag/data/state storage with a CPU port and a snoop port.
// Rev    : 1.0 - initial release
// ============================================================================
module msi_cache_array
   import msi_pkg::*;
#(
   parameter int IDX_W  = 4,
   parameter int TAG_W  = 26,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  cpu_idx,
   output logic [TAG_W-1:0]  cpu_tag,
   output logic [DATA_W-1:0] cpu_data,
   output line_state_t       cpu_state,
   input  logic              cpu_line_we,
   input  logic              cpu_state_we,
   input  logic [TAG_W-1:0]  cpu_wr_tag,
   input  logic [DATA_W-1:0] cpu_wr_data,
   input  line_state_t       cpu_wr_state,
   input  logic [IDX_W-1:0]  snp_idx,
   output logic [TAG_W-1:0]  snp_tag,
   output logic [DATA_W-1:0] snp_data,
   output line_state_t       snp_state,
   input  logic              snp_state_we,
   input  line_state_t       snp_wr_state
);

   localparam int NUM_LINES = 2 ** IDX_W;

   logic [TAG_W-1:0]  r_tag   [NUM_LINES];
   logic [DATA_W-1:0] r_data  [NUM_LINES];
   line_state_t       r_state [NUM_LINES];

   assign cpu_tag   = r_tag[cpu_idx];
   assign cpu_data  = r_data[cpu_idx];
   assign cpu_state = r_state[cpu_idx];
   assign snp_tag   = r_tag[snp_idx];
   assign snp_data  = r_data[snp_idx];
   assign snp_state = r_state[snp_idx];

   // CPU-port state write is applied last so a fill or victim invalidate wins over a snoop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            r_state[i] <= LS_I;
         end
      end else begin
         if (snp_state_we) begin
            r_state[snp_idx] <= snp_wr_state;
         end
         if (cpu_state_we) begin
            r_state[cpu_idx] <= cpu_wr_state;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cpu_line_we) begin
         r_tag[cpu_idx]  <= cpu_wr_tag;
         r_data[cpu_idx] <= cpu_wr_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/msi_cache_controller.sv
`default_nettype none
// ============================================================================
// Module : msi_cache_controller
// Desc   : Private L1 data cache controller, MSI coherent over a snooping bus.
// Rev    : 1.0 - initial release
// ============================================================================
module msi_cache_controller
   import msi_pkg::*;
#(
   parameter int ADDR_W = MSI_ADDR_W,
   parameter int DATA_W = MSI_DATA_W,
   parameter int IDX_W  = MSI_IDX_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cache_rw,
   input  logic [ADDR_W-1:0] cache_addr,
   input  logic [DATA_W-1:0] cache_data_in,
   output logic [DATA_W-1:0] cache_data_out,
   output logic              cache_hit,
   output logic              cpu_stall,
   output logic              bus_req,
   input  logic              bus_gnt,
   output logic [1:0]        bus_cmd,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack,
   input  logic              snoop_valid,
   input  logic [1:0]        snoop_cmd,
   input  logic [ADDR_W-1:0] snoop_addr,
   output logic              snoop_flush,
   output logic [DATA_W-1:0] snoop_data
);

   localparam int TAG_W = ADDR_W - IDX_W - 2;

   fsm_state_t        r_state, w_next_state;
   logic [ADDR_W-1:0] r_req_addr;
   logic              r_req_rw;
   logic [DATA_W-1:0] r_req_wdata;
   logic              r_hit;
   logic [DATA_W-1:0] r_dout;

   logic [IDX_W-1:0]  w_cpu_idx, w_req_idx, w_snp_idx;
   logic [TAG_W-1:0]  w_cpu_tag, w_req_tag, w_snp_tag, w_arr_tag, w_arr_snp_tag, w_wr_tag;
   logic [DATA_W-1:0] w_arr_data, w_arr_snp_data, w_wr_data;
   line_state_t       w_arr_state, w_arr_snp_state, w_wr_state, w_snp_wr_state;
   logic              w_line_we, w_state_we, w_snp_we, w_snp_hit, w_snp_block;
   logic              w_conflict, w_tag_match, w_cpu_go, w_cpu_hit, w_bus_done;

   assign w_req_idx = msi_index(r_req_addr);
   assign w_req_tag = msi_tag(r_req_addr);
   assign w_cpu_idx = (r_state == ST_IDLE) ? msi_index(cache_addr) : w_req_idx;
   assign w_cpu_tag = (r_state == ST_IDLE) ? msi_tag(cache_addr) : w_req_tag;
   assign w_snp_idx = msi_index(snoop_addr);
   assign w_snp_tag = msi_tag(snoop_addr);

   msi_cache_array #(
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk          (clk),
      .reset        (reset),
      .cpu_idx      (w_cpu_idx),
      .cpu_tag      (w_arr_tag),
      .cpu_data     (w_arr_data),
      .cpu_state    (w_arr_state),
      .cpu_line_we  (w_line_we),
      .cpu_state_we (w_state_we),
      .cpu_wr_tag   (w_wr_tag),
      .cpu_wr_data  (w_wr_data),
      .cpu_wr_state (w_wr_state),
      .snp_idx      (w_snp_idx),
      .snp_tag      (w_arr_snp_tag),
      .snp_data     (w_arr_snp_data),
      .snp_state    (w_arr_snp_state),
      .snp_state_we (w_snp_we),
      .snp_wr_state (w_snp_wr_state)
   );

   // The line being filled is ignored by snoops; bus ordering makes the fill authoritative
   always_comb begin
      w_snp_block    = (r_state == ST_FILL) && (w_snp_idx == w_req_idx) && (w_snp_tag == w_req_tag);
      w_snp_hit      = snoop_valid && !w_snp_block && (w_arr_snp_state != LS_I) &&
                       (w_arr_snp_tag == w_snp_tag);
      snoop_flush    = 1'b0;
      snoop_data     = '0;
      w_snp_we       = 1'b0;
      w_snp_wr_state = LS_I;
      if (w_snp_hit) begin
         if (w_arr_snp_state == LS_M && (snoop_cmd == CMD_BUSRD || snoop_cmd == CMD_BUSRDX)) begin
            snoop_flush    = 1'b1;
            snoop_data     = w_arr_snp_data;
            w_snp_we       = 1'b1;
            w_snp_wr_state = (snoop_cmd == CMD_BUSRD) ? LS_S : LS_I;
         end else if (w_arr_snp_state == LS_S && snoop_cmd == CMD_BUSRDX) begin
            w_snp_we = 1'b1;
         end
      end
   end

   assign w_conflict  = w_snp_we && (w_snp_idx == w_cpu_idx);
   assign w_tag_match = (w_arr_tag == w_cpu_tag) && (w_arr_state != LS_I);
   assign w_cpu_go    = (r_state == ST_IDLE) && cpu_req && !w_conflict;
   assign w_cpu_hit   = w_cpu_go && w_tag_match && (!cache_rw || w_arr_state == LS_M);
   assign w_bus_done  = bus_gnt && bus_ack;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_cpu_go && !w_cpu_hit) begin
               if (w_tag_match || w_arr_state != LS_M) begin
                  w_next_state = ST_FILL;
               end else begin
                  w_next_state = ST_WB;
               end
            end
         end
         ST_WB:   if (w_bus_done) w_next_state = ST_FILL;
         ST_FILL: if (w_bus_done) w_next_state = ST_RESP;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      bus_req    = 1'b0;
      bus_cmd    = CMD_NONE;
      bus_addr   = '0;
      bus_wdata  = '0;
      cpu_stall  = 1'b1;
      w_line_we  = 1'b0;
      w_state_we = 1'b0;
      w_wr_tag   = w_cpu_tag;
      w_wr_data  = cache_data_in;
      w_wr_state = LS_I;
      case (r_state)
         ST_IDLE: begin
            cpu_stall = cpu_req && !w_cpu_hit;
            if (w_cpu_hit && cache_rw) begin
               w_line_we  = 1'b1;
               w_state_we = 1'b1;
               w_wr_state = LS_M;
            end
         end
         ST_WB: begin
            bus_req    = 1'b1;
            bus_cmd    = CMD_WB;
            bus_addr   = {w_arr_tag, w_req_idx, 2'b00};
            bus_wdata  = w_arr_data;
            w_state_we = w_bus_done;
         end
         ST_FILL: begin
            bus_req    = 1'b1;
            bus_cmd    = r_req_rw ? CMD_BUSRDX : CMD_BUSRD;
            bus_addr   = {w_req_tag, w_req_idx, 2'b00};
            w_line_we  = w_bus_done;
            w_state_we = w_bus_done;
            w_wr_tag   = w_req_tag;
            w_wr_data  = r_req_rw ? r_req_wdata : bus_rdata;
            w_wr_state = r_req_rw ? LS_M : LS_S;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_req_addr  <= '0;
         r_req_rw    <= 1'b0;
         r_req_wdata <= '0;
         r_hit       <= 1'b0;
         r_dout      <= '0;
      end else begin
         r_hit <= 1'b0;
         if (w_cpu_hit) begin
            r_hit  <= 1'b1;
            r_dout <= cache_rw ? cache_data_in : w_arr_data;
         end else if (r_state == ST_FILL && w_bus_done) begin
            r_hit  <= 1'b1;
            r_dout <= w_wr_data;
         end
         if (w_cpu_go && !w_cpu_hit) begin
            r_req_addr  <= cache_addr;
            r_req_rw    <= cache_rw;
            r_req_wdata <= cache_data_in;
         end
      end
   end

   assign cache_hit      = r_hit;
   assign cache_data_out = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_msi_cache_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_msi_cache_controller
// Desc   : Directed self-checking bench for msi_cache_controller.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_msi_cache_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cache_rw;
   logic [31:0] cache_addr, cache_data_in, cache_data_out;
   logic        cache_hit, cpu_stall, bus_req, bus_gnt, bus_ack;
   logic [1:0]  bus_cmd, snoop_cmd;
   logic [31:0] bus_addr, bus_wdata, bus_rdata, snoop_addr, snoop_data;
   logic        snoop_valid, snoop_flush;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   msi_cache_controller dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_req        (cpu_req),
      .cache_rw       (cache_rw),
      .cache_addr     (cache_addr),
      .cache_data_in  (cache_data_in),
      .cache_data_out (cache_data_out),
      .cache_hit      (cache_hit),
      .cpu_stall      (cpu_stall),
      .bus_req        (bus_req),
      .bus_gnt        (bus_gnt),
      .bus_cmd        (bus_cmd),
      .bus_addr       (bus_addr),
      .bus_wdata      (bus_wdata),
      .bus_rdata      (bus_rdata),
      .bus_ack        (bus_ack),
      .snoop_valid    (snoop_valid),
      .snoop_cmd      (snoop_cmd),
      .snoop_addr     (snoop_addr),
      .snoop_flush    (snoop_flush),
      .snoop_data     (snoop_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      cpu_req       = 1'b1;
      cache_rw      = rw;
      cache_addr    = addr;
      cache_data_in = wdata;
      #1;
   endtask

   task automatic wait_hit(input string tag, input logic [31:0] exp);
      int i = 0;
      while (!cache_hit && i < 20) begin
         @(negedge clk);
         #1;
         i++;
      end
      chk({tag, "_hit"}, {31'd0, cache_hit}, 32'd1);
      chk({tag, "_data"}, cache_data_out, exp);
      cpu_req = 1'b0;
   endtask

   // Acts as arbiter and memory: holds off one cycle, sends a stray ack, then grants
   task automatic serve_bus(input string tag, input logic [1:0] cmd, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata);
      int i = 0;
      while (!bus_req && i < 20) begin
         @(negedge clk);
         #1;
         i++;
      end
      chk({tag, "_req"}, {31'd0, bus_req}, 32'd1);
      chk({tag, "_cmd"}, {30'd0, bus_cmd}, {30'd0, cmd});
      chk({tag, "_addr"}, bus_addr, addr);
      if (cmd == 2'd3) chk({tag, "_wdata"}, bus_wdata, wdata);
      bus_ack = 1'b1;
      @(negedge clk);
      #1;
      chk({tag, "_hold"}, {29'd0, bus_req, bus_cmd}, {29'd0, 1'b1, cmd});
      bus_gnt   = 1'b1;
      bus_rdata = rdata;
      @(negedge clk);
      bus_gnt = 1'b0;
      bus_ack = 1'b0;
      #1;
   endtask

   task automatic snoop(input logic v, input logic [1:0] cmd, input logic [31:0] addr);
      @(negedge clk);
      snoop_valid = v;
      snoop_cmd   = cmd;
      snoop_addr  = addr;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      cpu_req = 1'b0; cache_rw = 1'b0; cache_addr = '0; cache_data_in = '0;
      bus_gnt = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
      snoop_valid = 1'b0; snoop_cmd = 2'd0; snoop_addr = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_outputs", {27'd0, cache_hit, cpu_stall, bus_req, bus_cmd}, 32'd0);
      chk("rst_flush", {31'd0, snoop_flush}, 32'd0);
      chk("rst_dout", cache_data_out, 32'd0);

      // 1: cold read miss then hit
      do_req(1'b0, 32'h40, 32'h0);
      chk("t1_stall", {31'd0, cpu_stall}, 32'd1);
      serve_bus("t1_fill", 2'd1, 32'h40, 32'h0, 32'hDEADBEEF);
      wait_hit("t1", 32'hDEADBEEF);
      do_req(1'b0, 32'h40, 32'h0);
      chk("t1b_nostall", {30'd0, cpu_stall, bus_req}, 32'd0);
      wait_hit("t1b", 32'hDEADBEEF);

      // 2: upgrade from S, then write hits in M
      do_req(1'b1, 32'h40, 32'h12345678);
      chk("t2_stall", {31'd0, cpu_stall}, 32'd1);
      serve_bus("t2_upg", 2'd2, 32'h40, 32'h0, 32'hFFFFFFFF);
      wait_hit("t2", 32'h12345678);
      do_req(1'b1, 32'h40, 32'h0F0F0F0F);
      chk("t2_wrhit_nostall", {30'd0, cpu_stall, bus_req}, 32'd0);
      wait_hit("t2_wrhit", 32'h0F0F0F0F);
      do_req(1'b1, 32'h40, 32'h12345678);
      wait_hit("t2_wrhit2", 32'h12345678);
      do_req(1'b0, 32'h40, 32'h0);
      chk("t2_rd_nostall", {31'd0, cpu_stall}, 32'd0);
      wait_hit("t2_rd", 32'h12345678);

      // 3: conflict miss evicts the dirty line
      do_req(1'b0, 32'h440, 32'h0);
      serve_bus("t3_wb", 2'd3, 32'h40, 32'h12345678, 32'h0);
      serve_bus("t3_fill", 2'd1, 32'h440, 32'h0, 32'h44004400);
      wait_hit("t3", 32'h44004400);

      // 4: write-miss over a clean victim, then snoops
      do_req(1'b1, 32'h80, 32'hCAFEF00D);
      serve_bus("t4_rdx", 2'd2, 32'h80, 32'h0, 32'h0);
      wait_hit("t4", 32'hCAFEF00D);
      snoop(1'b1, 2'd2, 32'hC0);
      chk("t4_snp_miss", {31'd0, snoop_flush}, 32'd0);
      snoop(1'b1, 2'd3, 32'h80);
      chk("t4_snp_wb", {31'd0, snoop_flush}, 32'd0);
      snoop(1'b1, 2'd1, 32'h80);
      chk("t4_flush", {31'd0, snoop_flush}, 32'd1);
      chk("t4_flush_data", snoop_data, 32'hCAFEF00D);
      @(negedge clk);
      #1;
      chk("t4_now_shared", {31'd0, snoop_flush}, 32'd0);
      snoop(1'b1, 2'd2, 32'h80);
      chk("t4_inv_noflush", {31'd0, snoop_flush}, 32'd0);
      snoop(1'b0, 2'd0, 32'h0);
      do_req(1'b0, 32'h80, 32'h0);
      chk("t4_rd_miss", {31'd0, cpu_stall}, 32'd1);
      serve_bus("t4_refill", 2'd1, 32'h80, 32'h0, 32'h80808080);
      wait_hit("t4_rd", 32'h80808080);

      // 5: read hit colliding with an invalidating snoop
      @(negedge clk);
      cpu_req = 1'b1; cache_rw = 1'b0; cache_addr = 32'h80;
      snoop_valid = 1'b1; snoop_cmd = 2'd2; snoop_addr = 32'h80;
      #1;
      chk("t5_stall", {31'd0, cpu_stall}, 32'd1);
      @(negedge clk);
      #1;
      chk("t5_nohit", {31'd0, cache_hit}, 32'd0);
      snoop_valid = 1'b0;
      #1;
      chk("t5_miss_stall", {31'd0, cpu_stall}, 32'd1);
      serve_bus("t5_fill", 2'd1, 32'h80, 32'h0, 32'h55AA55AA);
      wait_hit("t5", 32'h55AA55AA);

      // 6: reset in the middle of a fill
      do_req(1'b0, 32'h48, 32'h0);
      @(negedge clk);
      #1;
      chk("t6_fill_req", {31'd0, bus_req}, 32'd1);
      #2;
      reset   = 1'b1;
      cpu_req = 1'b0;
      #1;
      chk("t6_rst_bus", {29'd0, bus_req, bus_cmd}, 32'd0);
      chk("t6_rst_out", {30'd0, cache_hit, cpu_stall}, 32'd0);
      chk("t6_rst_addr", bus_addr, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      do_req(1'b0, 32'h80, 32'h0);
      chk("t6_miss", {31'd0, cpu_stall}, 32'd1);
      serve_bus("t6_fill", 2'd1, 32'h80, 32'h0, 32'h0A0A0A0A);
      wait_hit("t6", 32'h0A0A0A0A);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
